// File: rtl/rv_lsu_pkg.sv
// Shared definitions for the load/store controller: RV32I funct3 encodings,
// controller states and request legality helpers.
package rv_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_STORE  = 3'd2,
    ST_RMW_RD = 3'd3,
    ST_RMW_WR = 3'd4,
    ST_RESP   = 3'd5
  } lsu_state_e;

  // Stores have no unsigned variants, so only B/H/W are legal for them.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = ~we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    case (f3)
      F3_H, F3_HU: bad = off[0];
      F3_W:        bad = |off;
      default:     bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Core-side request/response and memory-side bus of the load/store controller.
// Handshake: a request transfers on a rising edge where req=1 and ready=1; the
// response is the single cycle with done=1 (err and rdata qualified by done).
interface lsu_ctrl_if;
  logic        req;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        ready;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic [31:0] mem_A;
  logic [31:0] mem_WD;
  logic        mem_WE;
  logic [31:0] mem_RD;

  modport slave (
    input  req, req_we, req_funct3, req_addr, req_wdata, mem_RD,
    output ready, done, err, rdata, mem_A, mem_WD, mem_WE
  );

  modport master (
    output req, req_we, req_funct3, req_addr, req_wdata, mem_RD,
    input  ready, done, err, rdata, mem_A, mem_WD, mem_WE
  );
endinterface

// File: rtl/lsu_align.sv
// Little-endian lane handling: load extraction/extension and sub-word store
// merge into the previously read memory word.
module lsu_align
  import rv_lsu_pkg::*;
(
  input  logic [31:0] ld_word,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  input  logic [31:0] st_wdata,
  output logic [31:0] ld_data,
  output logic [31:0] st_merged
);

  logic [7:0]  b_lane;
  logic [15:0] h_lane;

  always_comb begin
    b_lane = ld_word[{off, 3'b000} +: 8];
    h_lane = off[1] ? ld_word[31:16] : ld_word[15:0];
    case (funct3)
      F3_B:    ld_data = {{24{b_lane[7]}}, b_lane};
      F3_BU:   ld_data = {24'h0, b_lane};
      F3_H:    ld_data = {{16{h_lane[15]}}, h_lane};
      F3_HU:   ld_data = {16'h0, h_lane};
      default: ld_data = ld_word;
    endcase
  end

  always_comb begin
    st_merged = ld_word;
    case (funct3)
      F3_B: st_merged[{off, 3'b000} +: 8] = st_wdata[7:0];
      F3_H: begin
        if (off[1]) st_merged[31:16] = st_wdata[15:0];
        else        st_merged[15:0]  = st_wdata[15:0];
      end
      default: st_merged = st_wdata;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller in front of a word-wide data memory. Sub-word stores
// are done as read-modify-write since the memory only writes whole words.
module lsu_ctrl
  import rv_lsu_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  lsu_ctrl_if.slave   bus,
  output lsu_state_e  dbg_state
);

  lsu_state_e  state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] merge_q, merge_d;

  logic [31:0] ld_data;
  logic [31:0] st_merged;
  logic        req_bad;

  lsu_align u_align (
    .ld_word   (bus.mem_RD),
    .off       (addr_q[1:0]),
    .funct3    (f3_q),
    .st_wdata  (wdata_q),
    .ld_data   (ld_data),
    .st_merged (st_merged)
  );

  // Checks run on the live request inputs so the verdict is latched with them.
  always_comb begin
    req_bad = ~f3_legal(bus.req_we, bus.req_funct3)
            | misaligned(bus.req_funct3, bus.req_addr[1:0])
            | ({2'b00, bus.req_addr[31:2]} >= 32'(MEM_WORDS));
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    merge_d = merge_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          we_d    = bus.req_we;
          f3_d    = bus.req_funct3;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          err_d   = req_bad;
          if (req_bad)                  state_d = ST_RESP;
          else if (!bus.req_we)         state_d = ST_LOAD;
          else if (bus.req_funct3 == F3_W) state_d = ST_STORE;
          else                          state_d = ST_RMW_RD;
        end
      end
      ST_LOAD: begin
        rdata_d = ld_data;
        state_d = ST_RESP;
      end
      ST_STORE: state_d = ST_RESP;
      ST_RMW_RD: begin
        merge_d = st_merged;
        state_d = ST_RMW_WR;
      end
      ST_RMW_WR: state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
      merge_q <= 32'h0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      merge_q <= merge_d;
    end
  end

  // Write enable comes straight from state so a reset drops it at once.
  assign bus.mem_WE = (state_q == ST_STORE) || (state_q == ST_RMW_WR);
  assign bus.mem_WD = (state_q == ST_STORE)  ? wdata_q :
                      (state_q == ST_RMW_WR) ? merge_q : 32'h0;
  assign bus.mem_A  = (state_q == ST_IDLE) ? 32'h0 : {2'b00, addr_q[31:2]};
  assign bus.ready  = (state_q == ST_IDLE);
  assign bus.done   = (state_q == ST_RESP);
  assign bus.err    = (state_q == ST_RESP) && err_q;
  assign bus.rdata  = rdata_q;
  assign dbg_state  = state_q;

  logic unused_we;
  assign unused_we = we_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a byte-level memory/response model and a
// per-cycle compare process.
module tb_lsu_ctrl;
  import rv_lsu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lsu_ctrl_if bus();
  lsu_state_e dbg_state;

  lsu_ctrl #(.MEM_WORDS(1024)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Memory environment: combinational read, RD=0 while writing.
  logic [31:0] mem [0:1023];
  assign bus.mem_RD = bus.mem_WE ? 32'h0 : mem[bus.mem_A[9:0]];
  always @(posedge clk) if (bus.mem_WE) mem[bus.mem_A[9:0]] <= bus.mem_WD;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  // Model state and expectation queues.
  logic [31:0] ref_mem [0:1023];
  int          exp_t[$];
  logic        exp_err[$];
  logic        exp_ld[$];
  logic [31:0] exp_q[$];
  int          exp_wt[$];
  logic [31:0] exp_wa[$];
  logic [31:0] exp_wd[$];
  logic [31:0] model_rdata = 32'h0;
  logic [31:0] cur_idx = 32'h0;
  int          last_done = 0;
  logic        last_err = 1'b0;
  bit          chk_en = 1'b0;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic clear_model();
    exp_t.delete(); exp_err.delete(); exp_ld.delete(); exp_q.delete();
    exp_wt.delete(); exp_wa.delete(); exp_wd.delete();
  endtask

  // Expected outcome of one accepted request, derived byte by byte.
  task automatic model_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input int acc);
    int size, idx, lat, p;
    bit legal, bad;
    logic [31:0] v, w;
    legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    size  = 1 << f3[1:0];
    bad   = !legal || ((addr % size) != 0) || ((addr >> 2) >= 1024);
    idx   = int'(addr >> 2);
    cur_idx = addr >> 2;
    if (bad) begin
      exp_t.push_back(acc); exp_err.push_back(1'b1); exp_ld.push_back(1'b0); exp_q.push_back(32'h0);
    end else if (!we) begin
      v = ref_mem[idx] >> (8 * (addr % 4));
      if (size == 1) begin
        v = v & 32'hFF;
        if (!f3[2] && v[7]) v = v | 32'hFFFFFF00;
      end else if (size == 2) begin
        v = v & 32'hFFFF;
        if (!f3[2] && v[15]) v = v | 32'hFFFF0000;
      end
      exp_t.push_back(acc + 1); exp_err.push_back(1'b0); exp_ld.push_back(1'b1); exp_q.push_back(v);
    end else begin
      w = ref_mem[idx];
      for (int i = 0; i < size; i++) begin
        p = int'(addr % 4) + i;
        w[8*p +: 8] = wd[8*i +: 8];
      end
      ref_mem[idx] = w;
      lat = (size == 4) ? 2 : 3;
      exp_wt.push_back(acc + lat - 2); exp_wa.push_back(addr >> 2); exp_wd.push_back(w);
      exp_t.push_back(acc + lat - 1); exp_err.push_back(1'b0); exp_ld.push_back(1'b0); exp_q.push_back(32'h0);
    end
  endtask

  // Per-cycle compare, sampled 1 time unit after the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (chk_en) begin
        chk("ready", {31'h0, bus.ready}, {31'h0, exp_t.size() == 0});
        chk("mem_A", bus.mem_A, (exp_t.size() != 0) ? cur_idx : 32'h0);
        if (exp_wt.size() != 0 && exp_wt[0] == cycle) begin
          chk("mem_WE", {31'h0, bus.mem_WE}, 32'h1);
          chk("wr_addr", bus.mem_A, exp_wa[0]);
          chk("wr_data", bus.mem_WD, exp_wd[0]);
          void'(exp_wt.pop_front()); void'(exp_wa.pop_front()); void'(exp_wd.pop_front());
        end else begin
          chk("mem_WE_idle", {31'h0, bus.mem_WE}, 32'h0);
          chk("mem_WD_idle", bus.mem_WD, 32'h0);
        end
        if (exp_t.size() != 0 && exp_t[0] == cycle) begin
          chk("done", {31'h0, bus.done}, 32'h1);
          chk("err", {31'h0, bus.err}, {31'h0, exp_err[0]});
          if (exp_ld[0]) model_rdata = exp_q[0];
          last_done = cycle;
          last_err  = bus.err;
          void'(exp_t.pop_front()); void'(exp_err.pop_front());
          void'(exp_ld.pop_front()); void'(exp_q.pop_front());
        end else begin
          chk("done_idle", {31'h0, bus.done}, 32'h0);
          chk("err_idle", {31'h0, bus.err}, 32'h0);
        end
        chk("rdata", bus.rdata, model_rdata);
      end
    end
  end

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output int acc);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ready) begin
      checks++; errors++;
      $display("FAIL ready_timeout: ready stayed 0 for %0d cycles", n);
    end
    bus.req = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
    bus.req_addr = addr; bus.req_wdata = wd;
    @(posedge clk);
    #1;
    acc = cycle;
    bus.req = 1'b0;
    bus.req_we = 1'($urandom_range(0, 1));
    bus.req_funct3 = 3'($urandom_range(0, 7));
    bus.req_addr = $urandom();
    bus.req_wdata = $urandom();
    model_req(we, f3, addr, wd, acc);
  endtask

  task automatic do_op(input string name, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input int lit_lat, input logic lit_err, input logic [31:0] lit_rdata);
    int acc, n;
    issue(we, f3, addr, wd, acc);
    n = 0;
    while (exp_t.size() != 0 && n < 20) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (exp_t.size() != 0) begin
      checks++; errors++;
      $display("FAIL %s_timeout: no done within %0d cycles", name, n);
      clear_model();
    end else begin
      chk({name, "_lat"}, 32'(last_done - acc + 1), 32'(lit_lat));
      chk({name, "_err"}, {31'h0, last_err}, {31'h0, lit_err});
      chk({name, "_rdata"}, bus.rdata, lit_rdata);
    end
  endtask

  initial begin
    int acc, n;
    bus.req = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b000;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 32'h0;
      ref_mem[i] = 32'h0;
    end
    mem[4] = 32'h8899AABB;    ref_mem[4] = 32'h8899AABB;
    mem[9] = 32'h11223344;    ref_mem[9] = 32'h11223344;
    mem[1023] = 32'hCAFEF00D; ref_mem[1023] = 32'hCAFEF00D;

    reset = 1'b1;
    #2 reset = 1'b0;
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst_ready", {31'h0, bus.ready}, 32'h1);
    chk("rst_done", {31'h0, bus.done}, 32'h0);
    chk("rst_err", {31'h0, bus.err}, 32'h0);
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_we", {31'h0, bus.mem_WE}, 32'h0);
    chk("rst_wd", bus.mem_WD, 32'h0);
    chk("rst_a", bus.mem_A, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    chk_en = 1'b1;

    do_op("lb_12",   1'b0, F3_B,  32'h12, 32'h0, 2, 1'b0, 32'hFFFFFF99);
    do_op("lbu_12",  1'b0, F3_BU, 32'h12, 32'h0, 2, 1'b0, 32'h00000099);
    do_op("lh_12",   1'b0, F3_H,  32'h12, 32'h0, 2, 1'b0, 32'hFFFF8899);
    do_op("lhu_10",  1'b0, F3_HU, 32'h10, 32'h0, 2, 1'b0, 32'h0000AABB);
    do_op("sw_20",   1'b1, F3_W,  32'h20, 32'hDEADBEEF, 2, 1'b0, 32'h0000AABB);
    do_op("lw_20",   1'b0, F3_W,  32'h20, 32'h0, 2, 1'b0, 32'hDEADBEEF);
    do_op("sh_22",   1'b1, F3_H,  32'h22, 32'h00001234, 3, 1'b0, 32'hDEADBEEF);
    do_op("lw_20b",  1'b0, F3_W,  32'h20, 32'h0, 2, 1'b0, 32'h1234BEEF);
    do_op("sb_21",   1'b1, F3_B,  32'h21, 32'hFFFFFF55, 3, 1'b0, 32'h1234BEEF);
    do_op("lw_20c",  1'b0, F3_W,  32'h20, 32'h0, 2, 1'b0, 32'h123455EF);
    do_op("lw_mis",  1'b0, F3_W,  32'h21, 32'h0, 1, 1'b1, 32'h123455EF);
    do_op("lh_mis",  1'b0, F3_H,  32'h23, 32'h0, 1, 1'b1, 32'h123455EF);
    do_op("st_f3_4", 1'b1, F3_BU, 32'h20, 32'h0, 1, 1'b1, 32'h123455EF);
    do_op("ld_f3_3", 1'b0, 3'b011, 32'h20, 32'h0, 1, 1'b1, 32'h123455EF);
    do_op("lw_oor",  1'b0, F3_W,  32'h1000, 32'h0, 1, 1'b1, 32'h123455EF);
    do_op("lw_ffc",  1'b0, F3_W,  32'hFFC, 32'h0, 2, 1'b0, 32'hCAFEF00D);
    do_op("sb_13",   1'b1, F3_B,  32'h13, 32'h0000007F, 3, 1'b0, 32'hCAFEF00D);
    do_op("lb_13",   1'b0, F3_B,  32'h13, 32'h0, 2, 1'b0, 32'h0000007F);
    do_op("lh_12b",  1'b0, F3_H,  32'h12, 32'h0, 2, 1'b0, 32'h00007F99);
    chk("mem4_final", mem[4], 32'h7F99AABB);

    // Reset while the RMW write is on the bus.
    issue(1'b1, F3_B, 32'h24, 32'h000000AA, acc);
    n = 0;
    while (!bus.mem_WE && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("rmw_we_seen", {31'h0, bus.mem_WE}, 32'h1);
    chk("rmw_wd", bus.mem_WD, 32'h112233AA);
    chk_en = 1'b0;
    reset = 1'b0;
    #1;
    chk("rst_mid_we", {31'h0, bus.mem_WE}, 32'h0);
    chk("rst_mid_a", bus.mem_A, 32'h0);
    chk("rst_mid_ready", {31'h0, bus.ready}, 32'h1);
    chk("rst_mid_rdata", bus.rdata, 32'h0);
    clear_model();
    model_rdata = 32'h0;
    ref_mem[9] = 32'h11223344;
    @(posedge clk);
    #1;
    chk("mem9_kept", mem[9], 32'h11223344);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rel_ready", {31'h0, bus.ready}, 32'h1);
    chk("rel_done", {31'h0, bus.done}, 32'h0);
    @(posedge clk);
    chk_en = 1'b1;
    do_op("lw_24",   1'b0, F3_W,  32'h24, 32'h0, 2, 1'b0, 32'h11223344);

    @(negedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
